// File: rtl/batch_grant_scheduler_if.sv
// ---------------------------------------------------------------------------
// batch_grant_scheduler_if
//   Bundles the request, control and grant handshake signals of
//   batch_grant_scheduler.
//   master : requester/consumer side (drives req, start, flush, grant_ready)
//   slave  : scheduler side (drives grant_valid, grant_idx, busy, done,
//            grant_count)
// ---------------------------------------------------------------------------
interface batch_grant_scheduler_if #(
  parameter int INPUTS = 12,
  parameter int STAGES = 7
);
  localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int CNT_W = $clog2(STAGES + 1);

  logic [INPUTS-1:0] req;
  logic              start;
  logic              flush;
  logic              grant_ready;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  grant_count;

  modport master (
    output req, start, flush, grant_ready,
    input  grant_valid, grant_idx, busy, done, grant_count
  );

  modport slave (
    input  req, start, flush, grant_ready,
    output grant_valid, grant_idx, busy, done, grant_count
  );
endinterface

// File: rtl/batch_grant_scheduler.sv
// ---------------------------------------------------------------------------
// batch_grant_scheduler
//   Shares one downstream resource among INPUTS requesters in batches. A start
//   strobe snapshots req; one SCAN cycle picks up to STAGES pending requesters
//   in round-robin order beginning at ptr; the picks are then issued one per
//   valid/ready handshake, followed by a one-cycle done pulse. ptr advances
//   past the last granted index so the next batch continues where this one
//   stopped.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of batch_grant_scheduler_if
//                (req/start/flush/grant_ready in; grant_valid/grant_idx/
//                 busy/done/grant_count out)
//   All outputs are decoded from flops only.
// ---------------------------------------------------------------------------
module batch_grant_scheduler #(
  parameter int INPUTS = 12,
  parameter int STAGES = 7
) (
  input logic                     clk,
  input logic                     rst_n,
  batch_grant_scheduler_if.slave  bus
);
  localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int CNT_W = $clog2(STAGES + 1);
  localparam logic [IDX_W:0]   INPUTS_W = (IDX_W + 1)'(INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic [INPUTS-1:0]             snap_q, snap_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [STAGES-1:0][IDX_W-1:0]  list_q, list_d;
  logic [CNT_W-1:0]              k_q, k_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  // Round-robin search: rotate snap so bit j is requester (ptr+j) mod INPUTS,
  // then collect the first STAGES set bits in ascending j.
  logic [2*INPUTS-1:0]           snap_dbl;
  logic [INPUTS-1:0]             snap_rot;
  logic [STAGES-1:0][IDX_W-1:0]  scan_list;
  logic [CNT_W-1:0]              scan_n;

  always_comb begin
    logic [IDX_W:0] pos;
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    snap_dbl  = {snap_q, snap_q} >> ptr_q;
    snap_rot  = snap_dbl[INPUTS-1:0];
    scan_list = '0;
    scan_n    = '0;
    pos       = '0;
    for (int j = 0; j < INPUTS; j++) begin
      pos = {1'b0, ptr_q} + (IDX_W + 1)'(j);
      if (pos >= INPUTS_W) pos = pos - INPUTS_W;
      if (snap_rot[j] && (scan_n != CNT_W'(STAGES))) begin
        for (int s = 0; s < STAGES; s++) begin
          if (scan_n == CNT_W'(s)) scan_list[s] = pos[IDX_W-1:0];
        end
        scan_n = scan_n + CNT_W'(1);
      end
    end
  end

  // Current grant (list[k]) and last grant of the batch (list[n-1]).
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] last_idx;

  always_comb begin
    cur_idx  = '0;
    last_idx = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (k_q == CNT_W'(s))       cur_idx  = list_q[s];
      if (cnt_q == CNT_W'(s + 1)) last_idx = list_q[s];
    end
  end

  logic handshake;
  assign handshake = (state_q == S_ISSUE) && bus.grant_ready;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ptr_d   = ptr_q;
    list_d  = list_q;
    k_d     = k_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d  = bus.req;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        list_d  = scan_list;
        cnt_d   = scan_n;
        k_d     = '0;
        state_d = (scan_n == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          if (k_q + CNT_W'(1) == cnt_q) state_d = S_DONE;
          else                          k_d     = k_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (cnt_q != '0) ptr_d = (last_idx == LAST_IDX) ? '0 : last_idx + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition: drop to IDLE and keep all batch
    // bookkeeping (ptr, grant_count) as it was. In IDLE this also blocks start.
    if (bus.flush) begin
      state_d = S_IDLE;
      snap_d  = snap_q;
      ptr_d   = ptr_q;
      list_d  = list_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from the same edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      ptr_q   <= '0;
      // NOTE: the grant list is reset too, so grant_idx reads 0 after reset
      // instead of exposing stale indices from an interrupted batch.
      list_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
      list_q  <= list_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant_valid = (state_q == S_ISSUE);
  assign bus.grant_idx   = cur_idx;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.grant_count = cnt_q;

endmodule

// File: tb/tb_batch_grant_scheduler.sv
// ---------------------------------------------------------------------------
// tb_batch_grant_scheduler
//   Self-checking bench for batch_grant_scheduler (INPUTS=12, STAGES=7).
//   Expected grant orders are hand-derived constants; they are queued when a
//   batch is started and popped on every accepted grant.
// ---------------------------------------------------------------------------
module tb_batch_grant_scheduler;
  localparam int INPUTS = 12;
  localparam int STAGES = 7;

  logic clk;
  logic rst_n;

  batch_grant_scheduler_if #(.INPUTS(INPUTS), .STAGES(STAGES)) bus ();

  batch_grant_scheduler #(.INPUTS(INPUTS), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sb[$];

  // exp holds the grant order one hex digit per grant, first grant in the
  // least significant digit (so 28'h203 means 3, then 0, then 2).
  typedef struct packed {
    logic        rst_first;
    logic [11:0] req;
    logic [3:0]  n;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle; any grant accepted in this cycle is scored at negedge.
  task automatic tick();
    int exp_i;
    @(negedge clk);
    if (bus.grant_valid === 1'b1 && bus.grant_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got idx %0d expected no grant (t=%0t)", bus.grant_idx, $time);
      end else begin
        exp_i = sb.pop_front();
        check("grant_idx", 32'(bus.grant_idx), 32'(exp_i));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input logic [11:0] r, input int n, input logic [27:0] e);
    int cyc;
    for (int i = 0; i < n; i++) sb.push_back(int'(e[i*4 +: 4]));
    bus.req   = r;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.req   = ~r;   // must be ignored after the snapshot
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("scan_no_valid", 32'(bus.grant_valid), 32'd0);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("done_cycle", 32'(cyc), 32'(n + 1));
    check("grant_count", 32'(bus.grant_count), 32'(n));
    check("all_grants_seen", 32'(sb.size()), 32'd0);
    tick();
    check("busy_drop", 32'(bus.busy), 32'd0);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    sb.delete();
    bus.req = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rst_first: 1'b0, req: 12'h005, n: 4'd2, exp: 28'h20};       // ptr 0 -> 3
    vecs[1] = '{rst_first: 1'b0, req: 12'h00D, n: 4'd3, exp: 28'h203};      // wrap, ptr stays 3
    vecs[2] = '{rst_first: 1'b0, req: 12'h000, n: 4'd0, exp: 28'h0};        // empty, ptr 3
    vecs[3] = '{rst_first: 1'b0, req: 12'h00D, n: 4'd3, exp: 28'h203};      // ptr unchanged by empty
    vecs[4] = '{rst_first: 1'b0, req: 12'h800, n: 4'd1, exp: 28'hB};        // ptr 11+1 wraps to 0
    vecs[5] = '{rst_first: 1'b1, req: 12'hFFF, n: 4'd7, exp: 28'h6543210};  // overflow, ptr 7
    vecs[6] = '{rst_first: 1'b0, req: 12'hFFF, n: 4'd7, exp: 28'h10BA987};  // fairness, ptr 2
    vecs[7] = '{rst_first: 1'b0, req: 12'h007, n: 4'd3, exp: 28'h102};      // shows ptr was 2

    bus.req         = '0;
    bus.start       = 1'b0;
    bus.flush       = 1'b0;
    bus.grant_ready = 1'b1;
    rst_n           = 1'b0;
    #2;
    check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_grant_count", 32'(bus.grant_count), 32'd0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_batch(vecs[i].req, int'(vecs[i].n), vecs[i].exp);
    end

    // Backpressure (ptr 2): req 0x840 -> 6 held for 3 stalled cycles, then 11.
    sb.push_back(6);
    sb.push_back(11);
    bus.grant_ready = 1'b0;
    bus.req         = 12'h840;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_held", 32'(bus.grant_valid), 32'd1);
      check("bp_idx_held", 32'(bus.grant_idx), 32'd6);
      tick();
    end
    bus.grant_ready = 1'b1;
    tick();
    check("bp_second_idx", 32'(bus.grant_idx), 32'd11);
    tick();
    check("bp_done", 32'(bus.done), 32'd1);
    check("bp_grant_count", 32'(bus.grant_count), 32'd2);
    check("bp_queue_empty", 32'(sb.size()), 32'd0);
    tick();
    sb.delete();

    // Flush after first of 3 grants (ptr 0); start during ISSUE is ignored.
    sb.push_back(0);
    bus.req   = 12'h007;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("fl_first_idx", 32'(bus.grant_idx), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.grant_ready = 1'b0;
    bus.flush       = 1'b1;
    check("fl_second_idx", 32'(bus.grant_idx), 32'd1);
    tick();
    bus.flush       = 1'b0;
    bus.grant_ready = 1'b1;
    check("fl_busy", 32'(bus.busy), 32'd0);
    check("fl_valid", 32'(bus.grant_valid), 32'd0);
    check("fl_grant_count", 32'(bus.grant_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("fl_no_done", 32'(bus.done), 32'd0);
      check("fl_no_restart", 32'(bus.busy), 32'd0);
      tick();
    end
    check("fl_queue_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    run_batch(12'h00F, 4, 28'h3210);     // ptr still 0 after flush; -> 4
    run_batch(12'h000, 0, 28'h0);        // empty batch; ptr stays 4
    run_batch(12'h01F, 5, 28'h32104);    // 4 first proves ptr 4; -> 4

    // start together with flush in IDLE: no batch.
    bus.req   = 12'h001;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start_flush_idle", 32'(bus.busy), 32'd0);
    tick();
    check("start_flush_no_done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-ISSUE (ptr 4): outputs clear without an edge.
    bus.grant_ready = 1'b0;
    bus.req         = 12'h0F0;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid_valid", 32'(bus.grant_valid), 32'd1);
    check("mid_idx", 32'(bus.grant_idx), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.grant_valid), 32'd0);
    check("async_idx", 32'(bus.grant_idx), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_done", 32'(bus.done), 32'd0);
    check("async_count", 32'(bus.grant_count), 32'd0);
    bus.grant_ready = 1'b1;
    do_reset();
    run_batch(12'h021, 2, 28'h50);       // 0 before 5 proves ptr reset to 0

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
